// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- sequential unsigned restoring divider.
//
// Divides an unsigned DIVIDEND_W-bit dividend by an unsigned DIVISOR_W-bit
// divisor. It develops one quotient bit per clock, MSB first. With the default
// widths it reverses the 4x4 -> 8 multiplier: a product divided by one factor
// gives the other factor. It is also used as a golden check on multiplier
// results.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset; aborts any operation
//   start        in   request; sampled only while idle
//   dividend     in   DIVIDEND_W  unsigned dividend, captured with start
//   divisor      in   DIVISOR_W   unsigned divisor, captured with start
//   busy         out  high while iterating (DIVIDEND_W cycles)
//   done         out  one-cycle pulse; result outputs are valid
//   quotient     out  DIVIDEND_W  unsigned quotient
//   remainder    out  DIVISOR_W   unsigned remainder
//   div_by_zero  out  captured divisor was zero (quotient = all ones)
//
// Timing: start accepted in cycle 0 -> busy in cycles 1..DIVIDEND_W -> done in
// cycle DIVIDEND_W+1. A zero divisor skips the iteration, so done comes in
// cycle 1. The result registers change only on the edge that enters FIN.
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Dividend shift register. Dividend bits leave at the MSB, and quotient bits
  // enter at the LSB. After DIVIDEND_W steps it holds the whole quotient.
  logic [DIVIDEND_W-1:0] r_shift;
  logic [DIVISOR_W-1:0]  r_divisor;
  // The partial remainder is always smaller than the divisor, so its top bit
  // would always be 0. Storing only DIVISOR_W bits loses nothing.
  logic [DIVISOR_W-1:0]  r_rem;
  logic [CNT_W-1:0]      r_cnt;

  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_dbz;

  // FSM decode strobes
  logic w_accept;     // IDLE with start and a nonzero divisor
  logic w_zero_div;   // IDLE with start and a zero divisor
  logic w_run;        // one iteration step this cycle
  logic w_last;       // the final iteration step (counter reaches 0)

  // Datapath for one iteration step
  logic [DIVISOR_W:0]    w_trial;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_diff;
  logic [DIVISOR_W-1:0]  w_rem_nxt;
  logic [DIVIDEND_W-1:0] w_shift_nxt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked processes use non-blocking (<=) assignments only, so every
  // register samples the values from before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first. Without the default,
  // any path that left a signal unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_zero_div  = 1'b0;
    w_run       = 1'b0;
    w_last      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            w_zero_div  = 1'b1;
            w_state_nxt = S_FIN;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end

      S_RUN: begin
        busy  = 1'b1;
        w_run = 1'b1;
        // The counter moves from 1 to 0 on this edge, so this is the last step.
        if (r_cnt == CNT_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_FIN;
        end
      end

      S_FIN: begin
        // Go back to IDLE unconditionally. A start seen here is dropped.
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One restoring-division step
  // ---------------------------------------------------------------------------
  always_comb begin
    w_trial   = {r_rem, r_shift[DIVIDEND_W-1]};
    w_ge      = (w_trial >= {1'b0, r_divisor});
    // Subtract at DIVISOR_W bits only. The result is used only when
    // trial >= divisor, and then the true difference is below the divisor.
    // That means it fits, and the dropped borrow bit is always 0.
    w_diff    = w_trial[DIVISOR_W-1:0] - r_divisor;
    w_rem_nxt = w_ge ? w_diff : w_trial[DIVISOR_W-1:0];
    w_shift_nxt = {r_shift[DIVIDEND_W-2:0], w_ge};
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift   <= dividend;
        r_divisor <= divisor;
        r_rem     <= '0;
        r_cnt     <= CNT_W'(DIVIDEND_W);
      end else if (w_run) begin
        r_shift <= w_shift_nxt;
        r_rem   <= w_rem_nxt;
        r_cnt   <= r_cnt - CNT_W'(1);
      end

      // Results load only on the edge that enters FIN. They then hold through
      // IDLE and through the whole of the next RUN.
      if (w_zero_div) begin
        r_quotient  <= '1;
        r_remainder <= '0;
        r_dbz       <= 1'b1;
      end else if (w_last) begin
        r_quotient  <= w_shift_nxt;
        r_remainder <= w_rem_nxt;
        r_dbz       <= 1'b0;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential unsigned integer divider; the inverse of the 4x4 -> 8 combinational multiplier block.
- Takes an 8-bit dividend (a product) and a 4-bit divisor.
- Produces quotient and remainder by restoring long division, one quotient bit per clock.
- Used where division must be computed in logic rather than solved by annealing, and as a golden check on multiplier results.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- dividend  input  DIVIDEND_W  unsigned dividend, captured with start.
- divisor  input  DIVISOR_W  unsigned divisor, captured with start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; result valid.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  set when the captured divisor was 0.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - Reset with reset high at a rising edge: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal partial remainder, shift register and counter are cleared.
  - Reset overrides start and aborts any operation in progress.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 with divisor!=0: latch operands, clear partial remainder R (DIVISOR_W+1 bits), counter=DIVIDEND_W, go to RUN.
  - start=1 with divisor==0: go to FIN. Load quotient=all ones, remainder=0, div_by_zero=1.
  - start=0: stay in IDLE. Outputs hold their last values.
- RUN (busy=1): on each edge:
  - T = {R[DIVISOR_W-1:0], msb of dividend shift register}; shift the dividend left by 1.
  - If T >= divisor: R = T - divisor and shift in quotient bit 1.
  - Else: R = T and shift in quotient bit 0.
  - Decrement the counter.
  - On the edge where the counter reaches 0: write quotient and remainder registers, div_by_zero=0, go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE unconditionally.
- Timing:
  - start high in cycle 0 -> busy high in cycles 1..DIVIDEND_W -> done high in cycle DIVIDEND_W+1 (cycle 9 by default).
  - Divide-by-zero: done high in cycle 1, busy never asserted.
- Output holding:
  - quotient, remainder and div_by_zero change only on the edge that enters FIN.
  - They hold until the next completion. They do not change during RUN.
- start handling:
  - start while in RUN or FIN is ignored; it is not queued.
  - start high in the FIN cycle is also ignored. The earliest accepted restart is the cycle after done.
- Arithmetic:
  - Unsigned throughout. Invariant: dividend = quotient*divisor + remainder, with remainder < divisor.
  - Quotient is full DIVIDEND_W width; no overflow is possible for divisor >= 1.
- Operand changes on dividend/divisor inputs after capture have no effect.

Test Plan:
- Basic: dividend=143, divisor=13, start pulse in cycle 0 -> busy cycles 1-8; done in cycle 9; quotient=11, remainder=0, div_by_zero=0.
- Remainder and back-to-back:
  - 100/7 -> q=14, r=2.
  - Then start in the cycle after done with 225/15 -> q=15, r=0, done 9 cycles later.
- Boundaries:
  - 255/1 -> q=255, r=0.
  - 0/9 -> q=0, r=0.
  - 6/15 -> q=0, r=6.
  - 255/15 -> q=17, r=0.
- Divide by zero and invariant:
  - 9/0 -> done in cycle 1, q=255, r=0, div_by_zero=1, busy stays 0.
  - A following 20/3 -> q=6, r=2, div_by_zero=0.
  - Exhaustive sweep of all 256x15 nonzero-divisor pairs checks the invariant.
- Ignored start: start 200/9, then pulse start with 50/5 in cycle 4 -> only one done (cycle 9), q=22, r=2.
- Reset mid-operation: reset high in cycle 5 of 143/13 -> next cycle all outputs 0, state IDLE, no done; a fresh 143/13 then completes normally.
